sump_reply_sender: RTL and testbench

//  Parametrised replacement for the SUMP reply path; sits between the command decoder and the UART transmitter.

---
 rtl/sump_reply_sender_pkg.sv | 92 +++++++++
 rtl/sump_reply_sender_if.sv | 28 ++
 rtl/sump_reply_rom.sv | 30 +++
 rtl/sump_reply_sender.sv | 139 +++++++++++++
 tb/tb_sump_reply_sender.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sump_reply_sender_pkg.sv
// sump_meta_pkg: shared types, token values and the elaboration-time ROM
// image builder for the SUMP reply sender.
//   reply_kind_e : request kinds from the command decoder
//   state_e      : reply FSM states
//   build_rom()  : packs ID word + metadata tokens into one byte image
package sump_meta_pkg;

    typedef enum logic [1:0] {
        RK_ID    = 2'd0,
        RK_META  = 2'd1,
        RK_RSVD2 = 2'd2,
        RK_RSVD3 = 2'd3
    } reply_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } state_e;

    localparam logic [7:0] TOK_NAME   = 8'h01;
    localparam logic [7:0] TOK_FW     = 8'h02;
    localparam logic [7:0] TOK_SMEM   = 8'h21;
    localparam logic [7:0] TOK_RATE   = 8'h23;
    localparam logic [7:0] TOK_PROBES = 8'h40;
    localparam logic [7:0] TOK_PROTO  = 8'h41;
    localparam logic [7:0] TOK_END    = 8'h00;

    localparam int unsigned ROM_MAX   = 256;
    localparam int unsigned STR_MAX   = 32;
    localparam int unsigned ID_BASE   = 0;
    localparam int unsigned ID_LEN    = 4;
    localparam int unsigned ID_END    = ID_BASE + ID_LEN - 1;
    localparam int unsigned META_BASE = ID_BASE + ID_LEN;

    // Strings are right-aligned in a fixed-width vector; unused high bytes are 0.
    typedef logic [8*STR_MAX-1:0] str_t;
    // Byte i of the image lives at bits [8*i +: 8].
    typedef logic [8*ROM_MAX-1:0] rom_image_t;

    function automatic int unsigned str_len(input str_t s);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < STR_MAX; i++)
            if (s[8*i +: 8] != 8'h00) n = i + 1;
        return n;
    endfunction

    // 01 name 00 02 fw 00 (4 framing bytes) + 21 w32, 23 w32, 40 np, 41 pv, 00 (15 bytes)
    function automatic int unsigned meta_len(input int unsigned name_len, input int unsigned fw_len);
        return name_len + fw_len + 19;
    endfunction

    function automatic rom_image_t build_rom(
        input logic [31:0] id_word,
        input str_t        name,
        input str_t        fw,
        input logic [31:0] smem,
        input logic [31:0] rate,
        input logic [7:0]  probes,
        input logic [7:0]  proto
    );
        rom_image_t  img;
        int unsigned p;
        int unsigned nl;
        int unsigned fl;
        img = '0;
        nl  = str_len(name);
        fl  = str_len(fw);
        for (int unsigned i = 0; i < ID_LEN; i++)
            img[8*(ID_BASE+i) +: 8] = id_word[8*(ID_LEN-1-i) +: 8];
        p = META_BASE;
        img[8*p +: 8] = TOK_NAME; p++;
        for (int unsigned i = nl; i > 0; i--) begin img[8*p +: 8] = name[8*(i-1) +: 8]; p++; end
        img[8*p +: 8] = TOK_END; p++;
        img[8*p +: 8] = TOK_FW; p++;
        for (int unsigned i = fl; i > 0; i--) begin img[8*p +: 8] = fw[8*(i-1) +: 8]; p++; end
        img[8*p +: 8] = TOK_END; p++;
        img[8*p +: 8] = TOK_SMEM; p++;
        for (int unsigned i = 4; i > 0; i--) begin img[8*p +: 8] = smem[8*(i-1) +: 8]; p++; end
        img[8*p +: 8] = TOK_RATE; p++;
        for (int unsigned i = 4; i > 0; i--) begin img[8*p +: 8] = rate[8*(i-1) +: 8]; p++; end
        img[8*p +: 8] = TOK_PROBES; p++;
        img[8*p +: 8] = probes; p++;
        img[8*p +: 8] = TOK_PROTO; p++;
        img[8*p +: 8] = proto; p++;
        img[8*p +: 8] = TOK_END;
        return img;
    endfunction

endpackage

// File: rtl/sump_reply_sender_if.sv
// sump_reply_sender_if: request, abort, status and transmit byte stream
// between command decoder / UART transmitter (master) and the reply sender (slave).
//   req_valid/req_kind/req_ready : request handshake (kind 0=ID, 1=METADATA)
//   abort                        : end the current reply after the in-flight byte
//   tx_valid/tx_byte/tx_ready    : reply byte stream
//   busy/done/aborted            : status and end-of-reply pulses
interface sump_reply_sender_if;
    logic       req_valid;
    logic [1:0] req_kind;
    logic       req_ready;
    logic       abort;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       aborted;

    modport master (
        output req_valid, req_kind, abort, tx_ready,
        input  req_ready, tx_valid, tx_byte, busy, done, aborted
    );

    modport slave (
        input  req_valid, req_kind, abort, tx_ready,
        output req_ready, tx_valid, tx_byte, busy, done, aborted
    );
endinterface

// File: rtl/sump_reply_rom.sv
// sump_reply_rom: synchronous-read byte ROM, contents fixed at elaboration.
//   clock : read clock        reset : sync active-low, clears data
//   en    : read enable       addr  : byte address
//   data  : registered read data, held while en is low
module sump_reply_rom
    import sump_meta_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter rom_image_t  INIT  = '0,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data
);
    logic [7:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        assign mem[i] = INIT[8*i +: 8];
    end

    always_ff @(posedge clock) begin
        if (!reset)
            data <= '0;
        else if (en)
            data <= mem[addr];
    end
endmodule

// File: rtl/sump_reply_sender.sv
// sump_reply_sender: serves SUMP ID and metadata replies from a parameter-built
// ROM as a valid/ready byte stream, with abort support.
//   clock : sole clock (posedge)     reset : synchronous, active-low
//   bus   : slave side of sump_reply_sender_if (request, abort, tx stream, status)
module sump_reply_sender
    import sump_meta_pkg::*;
#(
    parameter int unsigned ROM_DEPTH    = 64,
    parameter logic [31:0] ID_WORD      = 32'h4143_5350,
    parameter str_t        DEVICE_NAME  = "ACSP LA v2.00",
    parameter str_t        FW_VERSION   = "2.00",
    parameter logic [31:0] SAMPLE_BYTES = 32'd32768,
    parameter logic [31:0] MAX_RATE_HZ  = 32'd200_000_000,
    parameter logic [7:0]  NUM_PROBES   = 8'd8,
    parameter logic [7:0]  PROTO_VER    = 8'd2
) (
    input logic clock,
    input logic reset,
    sump_reply_sender_if.slave bus
);
    localparam int unsigned AW       = $clog2(ROM_DEPTH);
    localparam int unsigned META_END = META_BASE + meta_len(str_len(DEVICE_NAME), str_len(FW_VERSION)) - 1;
    localparam rom_image_t  ROM_IMAGE = build_rom(ID_WORD, DEVICE_NAME, FW_VERSION,
                                                  SAMPLE_BYTES, MAX_RATE_HZ, NUM_PROBES, PROTO_VER);

    localparam logic [AW-1:0] ID_BASE_A   = AW'(ID_BASE);
    localparam logic [AW-1:0] ID_END_A    = AW'(ID_END);
    localparam logic [AW-1:0] META_BASE_A = AW'(META_BASE);
    localparam logic [AW-1:0] META_END_A  = AW'(META_END);

    if (ROM_DEPTH < 2 || ROM_DEPTH > ROM_MAX) begin : g_bad_depth
        $error("ROM_DEPTH %0d outside 2..%0d", ROM_DEPTH, ROM_MAX);
    end
    // Guarantees addr never wraps: every range end is inside the ROM.
    if (META_END >= ROM_DEPTH) begin : g_rom_overflow
        $error("reply image of %0d bytes exceeds ROM_DEPTH %0d", META_END + 1, ROM_DEPTH);
    end

    state_e        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] end_addr;
    logic          abort_q;
    logic          tx_valid;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          req_ready;
    logic [7:0]    rom_data;
    reply_kind_e   kind;
    logic          abort_pending;
    logic          handshake;
    logic          rom_en;

    assign kind          = reply_kind_e'(bus.req_kind);
    assign abort_pending = abort_q | bus.abort;
    assign handshake     = tx_valid & bus.tx_ready;
    assign rom_en        = (state == ST_LOAD) & ~abort_pending;

    assign bus.req_ready = req_ready;
    assign bus.tx_valid  = tx_valid;
    assign bus.tx_byte   = rom_data;   // ROM output register doubles as tx_byte
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.aborted   = aborted;

    sump_reply_rom #(
        .DEPTH (ROM_DEPTH),
        .INIT  (ROM_IMAGE)
    ) u_rom (
        .clock (clock),
        .reset (reset),
        .en    (rom_en),
        .addr  (addr),
        .data  (rom_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            end_addr  <= '0;
            abort_q   <= 1'b0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (state != ST_IDLE && bus.abort)
                abort_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    // Reserved kinds fall through: consumed, no reply.
                    if (bus.req_valid && (kind == RK_ID || kind == RK_META)) begin
                        addr      <= (kind == RK_ID) ? ID_BASE_A : META_BASE_A;
                        end_addr  <= (kind == RK_ID) ? ID_END_A  : META_END_A;
                        state     <= ST_LOAD;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort_pending) begin
                        state   <= ST_FIN;
                        aborted <= 1'b1;
                    end else begin
                        state    <= ST_SEND;
                        tx_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        tx_valid <= 1'b0;
                        // Last byte wins over a coincident abort.
                        if (addr == end_addr) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else if (abort_pending) begin
                            state   <= ST_FIN;
                            aborted <= 1'b1;
                        end else begin
                            addr  <= addr + AW'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_FIN: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sump_reply_sender.sv
// Testbench for sump_reply_sender: directed and randomized replies checked
// against a byte-list model built from the protocol's token rules.
module tb_sump_reply_sender;
    localparam int MODE_NONE    = 0;   // no abort
    localparam int MODE_PRESENT = 1;   // abort while byte k is presented
    localparam int MODE_LOAD    = 2;   // abort in the gap before byte k

    logic clock = 1'b0;
    logic reset;

    sump_reply_sender_if bus();

    sump_reply_sender #(.ROM_DEPTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [7:0] id_q[$];
    logic [7:0] meta_q[$];
    logic [7:0] got_q[$];
    int n_done, n_abort, first_valid, done_cyc, last_hs_cyc;
    bit timed_out;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void meta_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) meta_q.push_back(w[8*i +: 8]);
    endfunction

    function automatic void meta_str(input logic [7:0] tok, input string s);
        meta_q.push_back(tok);
        for (int i = 0; i < s.len(); i++) meta_q.push_back(s[i]);
        meta_q.push_back(8'h00);
    endfunction

    function automatic void build_model();
        logic [31:0] w;
        w = 32'h4143_5350;
        id_q = {};
        meta_q = {};
        for (int i = 3; i >= 0; i--) id_q.push_back(w[8*i +: 8]);
        meta_str(8'h01, "ACSP LA v2.00");
        meta_str(8'h02, "2.00");
        meta_q.push_back(8'h21); meta_word(32'd32768);
        meta_q.push_back(8'h23); meta_word(32'd200_000_000);
        meta_q.push_back(8'h40); meta_q.push_back(8'd8);
        meta_q.push_back(8'h41); meta_q.push_back(8'd2);
        meta_q.push_back(8'h00);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [1:0] kind, input int idx);
        if (kind == 2'd0) return (idx < id_q.size()) ? id_q[idx] : 8'h00;
        return (idx < meta_q.size()) ? meta_q[idx] : 8'h00;
    endfunction

    task automatic run_reply(input string tag, input logic [1:0] kind, input int unsigned stall_pct,
                             input int mode, input int k, input bit stall_abort,
                             input int hold_idx, input int hold_n, input bit spam_req);
        bit prev_stall;
        bit fired;
        bit fin_seen;
        int held;
        prev_stall = 0; fired = 0; fin_seen = 0; held = 0;
        got_q = {};
        n_done = 0; n_abort = 0; first_valid = -1; done_cyc = -1; last_hs_cyc = -1; timed_out = 0;
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.abort     = 1'b0;
        bus.tx_ready  = 1'b1;
        step();
        for (int cyc = 1; cyc <= 4000 && !fin_seen; cyc++) begin
            bus.req_valid = spam_req;
            bus.req_kind  = spam_req ? 2'($urandom_range(0, 3)) : kind;
            bus.abort     = 1'b0;
            if (cyc == 1) begin
                check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
                check({tag, " req_ready_after_accept"}, 32'(bus.req_ready), 32'd0);
            end
            if (prev_stall) begin
                check({tag, " hold_valid"}, 32'(bus.tx_valid), 32'd1);
                check({tag, " hold_byte"}, 32'(bus.tx_byte), 32'(exp_byte(kind, got_q.size())));
            end
            if (bus.tx_valid && first_valid < 0) first_valid = cyc;
            if (bus.done || bus.aborted) begin
                n_done        = int'(bus.done);
                n_abort       = int'(bus.aborted);
                done_cyc      = cyc;
                fin_seen      = 1;
                bus.req_valid = 1'b0;
            end else begin
                bus.tx_ready = ($urandom_range(0, 99) >= stall_pct);
                if (bus.tx_valid && int'(got_q.size()) == hold_idx && held < hold_n) begin
                    bus.tx_ready = 1'b0;
                    held++;
                end
                if (!fired && mode == MODE_PRESENT && bus.tx_valid && int'(got_q.size()) == k) begin
                    bus.abort = 1'b1;
                    fired = 1;
                    if (stall_abort) bus.tx_ready = 1'b0;
                end
                if (!fired && mode == MODE_LOAD && bus.busy && !bus.tx_valid && int'(got_q.size()) == k) begin
                    bus.abort = 1'b1;
                    fired = 1;
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    got_q.push_back(bus.tx_byte);
                    last_hs_cyc = cyc;
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                step();
            end
        end
        if (!fin_seen) begin
            timed_out = 1;
        end else begin
            step();
            check({tag, " busy_after_end"}, 32'(bus.busy), 32'd0);
            check({tag, " req_ready_after_end"}, 32'(bus.req_ready), 32'd1);
            check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
            check({tag, " aborted_one_cycle"}, 32'(bus.aborted), 32'd0);
            check({tag, " tx_valid_after_end"}, 32'(bus.tx_valid), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.tx_ready  = 1'b1;
    endtask

    task automatic verify(input string tag, input logic [1:0] kind, input int mode, input int k,
                          input bit plain_timing);
        int len;
        int exp_n;
        bit exp_done;
        len      = (kind == 2'd0) ? id_q.size() : meta_q.size();
        exp_n    = (mode == MODE_NONE) ? len : (mode == MODE_PRESENT) ? k + 1 : k;
        exp_done = (mode == MODE_NONE) || (mode == MODE_PRESENT && k == len - 1);
        check({tag, " timeout"}, 32'(timed_out), 32'd0);
        check({tag, " byte_count"}, 32'(got_q.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_byte(kind, i)));
        check({tag, " done_pulse"}, 32'(n_done), 32'(exp_done));
        check({tag, " aborted_pulse"}, 32'(n_abort), 32'(!exp_done));
        check({tag, " latency"}, 32'(first_valid), (mode == MODE_LOAD && k == 0) ? 32'hFFFF_FFFF : 32'd2);
        if (exp_done)
            check({tag, " done_after_last_hs"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
        if (plain_timing)
            check({tag, " throughput"}, 32'(done_cyc), 32'(2 * exp_n + 1));
    endtask

    initial begin
        logic [1:0]  rk;
        int          rmode;
        int          rk_idx;
        int          rlen;
        int unsigned rstall;
        bit          rspam;

        build_model();
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'd0;
        bus.abort     = 1'b0;
        bus.tx_ready  = 1'b1;
        reset = 1'b0;
        repeat (3) step();
        check("reset tx_valid", 32'(bus.tx_valid), 32'd0);
        check("reset tx_byte", 32'(bus.tx_byte), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset aborted", 32'(bus.aborted), 32'd0);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b1;
        step();

        run_reply("id", 2'd0, 0, MODE_NONE, 0, 0, -1, 0, 0);
        verify("id", 2'd0, MODE_NONE, 0, 1);

        run_reply("meta", 2'd1, 0, MODE_NONE, 0, 0, -1, 0, 0);
        verify("meta", 2'd1, MODE_NONE, 0, 1);

        run_reply("meta_hold", 2'd1, 0, MODE_NONE, 0, 0, 2, 5, 0);
        verify("meta_hold", 2'd1, MODE_NONE, 0, 0);

        run_reply("abort6", 2'd1, 0, MODE_PRESENT, 5, 1, -1, 0, 0);
        verify("abort6", 2'd1, MODE_PRESENT, 5, 0);

        run_reply("abort_load", 2'd1, 0, MODE_LOAD, 3, 0, -1, 0, 0);
        verify("abort_load", 2'd1, MODE_LOAD, 3, 0);

        run_reply("abort_last", 2'd0, 0, MODE_PRESENT, 3, 0, -1, 0, 0);
        verify("abort_last", 2'd0, MODE_PRESENT, 3, 0);

        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        run_reply("idle_abort", 2'd0, 0, MODE_NONE, 0, 0, -1, 0, 0);
        verify("idle_abort", 2'd0, MODE_NONE, 0, 1);

        // Reset while a byte is presented and stalled.
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'd0;
        bus.tx_ready  = 1'b0;
        step();
        bus.req_valid = 1'b0;
        step();
        check("mid_send tx_valid", 32'(bus.tx_valid), 32'd1);
        reset = 1'b0;
        step();
        check("reset_in_send tx_valid", 32'(bus.tx_valid), 32'd0);
        check("reset_in_send busy", 32'(bus.busy), 32'd0);
        check("reset_in_send tx_byte", 32'(bus.tx_byte), 32'd0);
        reset = 1'b1;
        bus.tx_ready = 1'b1;
        step();
        run_reply("id_after_reset", 2'd0, 0, MODE_NONE, 0, 0, -1, 0, 0);
        verify("id_after_reset", 2'd0, MODE_NONE, 0, 1);

        run_reply("spam", 2'd1, 0, MODE_NONE, 0, 0, -1, 0, 1);
        verify("spam", 2'd1, MODE_NONE, 0, 1);

        for (int kk = 2; kk <= 3; kk++) begin
            bus.req_valid = 1'b1;
            bus.req_kind  = 2'(kk);
            step();
            bus.req_valid = 1'b0;
            for (int c = 0; c < 4; c++) begin
                check($sformatf("rsvd%0d req_ready c%0d", kk, c), 32'(bus.req_ready), 32'd1);
                check($sformatf("rsvd%0d busy c%0d", kk, c), 32'(bus.busy), 32'd0);
                check($sformatf("rsvd%0d tx_valid c%0d", kk, c), 32'(bus.tx_valid), 32'd0);
                check($sformatf("rsvd%0d done c%0d", kk, c), 32'(bus.done), 32'd0);
                step();
            end
        end

        for (int r = 0; r < 12; r++) begin
            rk     = 2'($urandom_range(0, 1));
            rlen   = (rk == 2'd0) ? id_q.size() : meta_q.size();
            rmode  = int'($urandom_range(0, 2));
            rk_idx = int'($urandom_range(0, rlen - 1));
            rstall = 25 * $urandom_range(0, 2);
            rspam  = 1'($urandom_range(0, 1));
            run_reply($sformatf("rand%0d", r), rk, rstall, rmode, rk_idx, 0, -1, 0, rspam);
            verify($sformatf("rand%0d", r), rk, rmode, rk_idx, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
